// File: rtl/axi_read_slave.sv
// ---------------------------------------------------------------------------
// axi_read_slave
//
// AXI4 read-only slave in front of a 32-bit word memory. One burst is served
// at a time: an address handshake in IDLE captures the request, then every
// beat spends one cycle in FETCH (memory read into the rdata register) and at
// least one cycle in DATA (presented until rready). A one-cycle DONE state
// separates consecutive bursts. The memory is loaded through a separate
// preload write port that is usable in any state.
//
// Parameters
//   MEM_WORDS      number of 32-bit words, 1..1024
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   s_axi_araddr   byte address, word index = araddr[11:2]
//   s_axi_arlen    beats minus one
//   s_axi_arsize   transfer size, only 3'b010 serviced
//   s_axi_arburst  00 FIXED, 01 INCR, 10/11 answered with SLVERR
//   s_axi_arvalid  address valid
//   s_axi_arready  address ready, high only in IDLE
//   s_axi_rdata    read data (zero on error beats)
//   s_axi_rresp    00 OKAY, 10 SLVERR
//   s_axi_rlast    final beat of the burst
//   s_axi_rvalid   read data valid
//   s_axi_rready   read data ready
//   mem_we         preload write enable
//   mem_waddr      preload word address (ignored when >= MEM_WORDS)
//   mem_wdata      preload write data
// ---------------------------------------------------------------------------
module axi_read_slave #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    input  logic [2:0]  s_axi_arsize,
    input  logic [1:0]  s_axi_arburst,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    input  logic        mem_we,
    input  logic [9:0]  mem_waddr,
    input  logic [31:0] mem_wdata
);

    // Index width that exactly covers the memory array.
    localparam int          AW          = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [10:0] MEM_WORDS_L = 11'(MEM_WORDS);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_FETCH = 2'd1;
    localparam logic [1:0]  ST_DATA  = 2'd2;
    localparam logic [1:0]  ST_DONE  = 2'd3;

    localparam logic [1:0]  BURST_FIXED = 2'b00;
    localparam logic [2:0]  SIZE_WORD   = 3'b010;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    if (MEM_WORDS < 1 || MEM_WORDS > 1024) begin : g_bad_mem_words
        $error("axi_read_slave: MEM_WORDS must be in 1..1024");
    end

    // -----------------------------------------------------------------------
    // State and captured request
    // -----------------------------------------------------------------------
    logic [1:0]  r_state;
    logic        r_arready;
    logic [11:0] r_addr;     // word-aligned byte address of the current beat
    logic [7:0]  r_cnt;      // beats remaining after the current one
    logic [2:0]  r_size;
    logic [1:0]  r_burst;

    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic        r_rlast;
    logic        r_rvalid;

    logic [31:0] r_mem [MEM_WORDS];

    // -----------------------------------------------------------------------
    // Beat decode
    // -----------------------------------------------------------------------
    logic [9:0]  w_rd_idx;
    logic        w_rd_in_range;
    logic        w_beat_err;
    logic [11:0] w_next_addr;
    logic        w_wr_in_range;
    logic        w_r_hs;

    assign w_rd_idx      = r_addr[11:2];
    assign w_rd_in_range = ({1'b0, w_rd_idx} < MEM_WORDS_L);

    // Reserved burst types (10, 11) are answered with an error on every
    // beat; the error is evaluated per beat so an INCR burst that walks past
    // the end of a small memory turns to SLVERR only for the missing words.
    assign w_beat_err    = (r_size != SIZE_WORD) || r_burst[1] || !w_rd_in_range;

    // FIXED holds the address; INCR and the reserved types step one word.
    // The 12-bit add wraps 0xFFC to 0x000 on its own.
    assign w_next_addr   = (r_burst == BURST_FIXED) ? r_addr : (r_addr + 12'd4);

    assign w_wr_in_range = ({1'b0, mem_waddr} < MEM_WORDS_L);
    assign w_r_hs        = r_rvalid && s_axi_rready;

    // -----------------------------------------------------------------------
    // Preload write port
    // -----------------------------------------------------------------------
    // NOTE: the memory array has no reset: its contents must survive rst, and
    // a resettable array would also prevent mapping onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we && w_wr_in_range) begin
            r_mem[mem_waddr[AW-1:0]] <= mem_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM and read data path
    // -----------------------------------------------------------------------
    // NOTE: all state here uses non-blocking assignments; that is also what
    // makes a same-cycle preload write and FETCH read return the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_arready <= 1'b0;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_rlast   <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_arready && s_axi_arvalid) begin
                        // Byte lanes are ignored: the data path is word-aligned.
                        r_addr    <= {s_axi_araddr[11:2], 2'b00};
                        r_cnt     <= s_axi_arlen;
                        r_size    <= s_axi_arsize;
                        r_burst   <= s_axi_arburst;
                        r_arready <= 1'b0;
                        r_state   <= ST_FETCH;
                    end else begin
                        // Only the first cycle after reset release reaches
                        // here with arready low; from then on IDLE keeps it high.
                        r_arready <= 1'b1;
                    end
                end

                ST_FETCH: begin
                    if (w_beat_err) begin
                        r_rdata <= '0;
                        r_rresp <= RESP_SLVERR;
                    end else begin
                        r_rdata <= r_mem[w_rd_idx[AW-1:0]];
                        r_rresp <= RESP_OKAY;
                    end
                    r_rlast  <= (r_cnt == 8'd0);
                    r_rvalid <= 1'b1;
                    r_state  <= ST_DATA;
                end

                ST_DATA: begin
                    // Outputs are held untouched until the handshake; there is
                    // deliberately no timeout on backpressure.
                    if (w_r_hs) begin
                        r_rvalid <= 1'b0;
                        r_rlast  <= 1'b0;
                        if (r_cnt == 8'd0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt   <= r_cnt - 8'd1;
                            r_addr  <= w_next_addr;
                            r_state <= ST_FETCH;
                        end
                    end
                end

                ST_DONE: begin
                    // arready rises together with the return to IDLE so the
                    // slave never accepts an address while still in DONE.
                    r_arready <= 1'b1;
                    r_state   <= ST_IDLE;
                end

                default: begin
                    r_arready <= 1'b0;
                    r_rvalid  <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign s_axi_arready = r_arready;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rlast   = r_rlast;
    assign s_axi_rvalid  = r_rvalid;

endmodule

// File: tb/tb_axi_read_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_read_slave
//
// Two instances of axi_read_slave (MEM_WORDS = 1024 and 256) share all
// inputs. For every request the bench derives the list of beats each instance
// must return from a shadow copy of its memory and pushes them into a
// per-instance queue; a monitor on the falling edge pops and compares on every
// R handshake, and also checks that stalled beats stay stable and that
// arready is low while data is pending.
// ---------------------------------------------------------------------------
module tb_axi_read_slave;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        rready;
    logic        mem_we;
    logic [9:0]  mem_waddr;
    logic [31:0] mem_wdata;

    logic        arready_a, rvalid_a, rlast_a;
    logic [31:0] rdata_a;
    logic [1:0]  rresp_a;
    logic        arready_b, rvalid_b, rlast_b;
    logic [31:0] rdata_b;
    logic [1:0]  rresp_b;

    always #5 clk = ~clk;

    axi_read_slave #(.MEM_WORDS(1024)) u_dut_a (
        .clk(clk), .rst(rst),
        .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready_a),
        .s_axi_rdata(rdata_a), .s_axi_rresp(rresp_a), .s_axi_rlast(rlast_a),
        .s_axi_rvalid(rvalid_a), .s_axi_rready(rready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    axi_read_slave #(.MEM_WORDS(256)) u_dut_b (
        .clk(clk), .rst(rst),
        .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready_b),
        .s_axi_rdata(rdata_b), .s_axi_rresp(rresp_b), .s_axi_rlast(rlast_b),
        .s_axi_rvalid(rvalid_b), .s_axi_rready(rready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    // -----------------------------------------------------------------------
    // Reference model state and scoreboard
    // -----------------------------------------------------------------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_mem [2][1024];
    int          mem_words [2] = '{1024, 256};
    beat_t       q0[$];
    beat_t       q1[$];
    bit          hold_v [2];
    beat_t       hold_b [2];
    int          n_pop  [2];
    int          rr_mode = 0;          // 0: always ready, 1: toggle, 2: random
    bit          coll_en = 1'b0;
    logic [31:0] coll_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic string nm(input string base, input int k);
        return $sformatf("%s[%0s]", base, (k == 0) ? "a" : "b");
    endfunction

    // Expected beats straight from the protocol rules: word-aligned start,
    // FIXED stays, everything else steps by 4 modulo 4096; an error beat is
    // any beat with a bad size, a reserved burst type, or a missing word.
    task automatic push_expected(input int k, input logic [11:0] addr, input logic [7:0] len,
                                 input logic [2:0] size, input logic [1:0] burst);
        int    a;
        int    idx;
        bit    err;
        beat_t b;
        a = int'(addr) & 32'hFFC;
        for (int i = 0; i <= int'(len); i++) begin
            idx    = a / 4;
            err    = (size != 3'b010) || (burst >= 2'd2) || (idx >= mem_words[k]);
            b.data = err ? 32'h0 : model_mem[k][idx];
            b.resp = err ? 2'b10 : 2'b00;
            b.last = (i == int'(len));
            if (k == 0) q0.push_back(b);
            else        q1.push_back(b);
            if (burst != 2'b00) a = (a + 4) % 4096;
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic beat_t pop_exp(input int k);
        if (k == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void model_write(input logic [9:0] wa, input logic [31:0] wd);
        for (int k = 0; k < 2; k++) begin
            if (int'(wa) < mem_words[k]) model_mem[k][wa] = wd;
        end
    endfunction

    // -----------------------------------------------------------------------
    // Monitor
    // -----------------------------------------------------------------------
    task automatic mon_one(input int k, input logic rv, input logic [31:0] d,
                           input logic [1:0] r, input logic l, input logic ar);
        beat_t e;
        if (hold_v[k]) begin
            check(nm("stall_rvalid", k), {31'b0, rv}, 32'd1);
            check(nm("stall_rdata", k), d, hold_b[k].data);
            check(nm("stall_rresp", k), {30'b0, r}, {30'b0, hold_b[k].resp});
            check(nm("stall_rlast", k), {31'b0, l}, {31'b0, hold_b[k].last});
        end
        if (rv) begin
            check(nm("arready_busy", k), {31'b0, ar}, 32'd0);
            if (rready) begin
                hold_v[k] = 1'b0;
                if (qsize(k) == 0) begin
                    check(nm("unexpected_beat", k), 32'd1, 32'd0);
                end else begin
                    e = pop_exp(k);
                    n_pop[k]++;
                    check(nm("rdata", k), d, e.data);
                    check(nm("rresp", k), {30'b0, r}, {30'b0, e.resp});
                    check(nm("rlast", k), {31'b0, l}, {31'b0, e.last});
                end
            end else begin
                hold_v[k]      = 1'b1;
                hold_b[k].data = d;
                hold_b[k].resp = r;
                hold_b[k].last = l;
            end
        end else begin
            hold_v[k] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            mon_one(0, rvalid_a, rdata_a, rresp_a, rlast_a, arready_a);
            mon_one(1, rvalid_b, rdata_b, rresp_b, rlast_b, arready_b);
        end
    end

    // rready pattern generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       rready = 1'b1;
                1:       rready = ~rready;
                default: rready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Stimulus tasks
    // -----------------------------------------------------------------------
    task automatic write_word(input logic [9:0] wa, input logic [31:0] wd);
        @(posedge clk);
        #1;
        mem_we    = 1'b1;
        mem_waddr = wa;
        mem_wdata = wd;
        model_write(wa, wd);
        @(posedge clk);
        #1;
        mem_we = 1'b0;
    endtask

    task automatic issue(input logic [11:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        bit ok;
        int lat;
        @(posedge clk);
        #1;
        araddr  = addr;
        arlen   = len;
        arsize  = size;
        arburst = burst;
        arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (arready_a && arready_b) begin
                ok = 1'b1;
                break;
            end
        end
        check("ar_handshake", {31'b0, ok}, 32'd1);
        if (!ok) begin
            arvalid = 1'b0;
            return;
        end
        push_expected(0, addr, len, size, burst);
        push_expected(1, addr, len, size, burst);
        @(posedge clk);
        #1;
        // Handshake edge has passed; scramble AR to show it is ignored while busy.
        arvalid = 1'b0;
        araddr  = 12'($urandom);
        arlen   = 8'($urandom);
        arsize  = 3'($urandom);
        arburst = 2'($urandom);
        if (coll_en) begin
            mem_we    = 1'b1;
            mem_waddr = addr[11:2];
            mem_wdata = coll_data;
        end
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (rvalid_a) break;
            if (lat == 1 && coll_en) begin
                @(posedge clk);
                #1;
                mem_we = 1'b0;
                model_write(addr[11:2], coll_data);
            end
        end
        check("first_rvalid_latency", lat, 32'd2);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && arready_a && arready_b) begin
                ok = 1'b1;
                break;
            end
        end
        check("burst_complete", {31'b0, ok}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_arready_a"}, {31'b0, arready_a}, 32'd0);
        check({tag, "_rvalid_a"},  {31'b0, rvalid_a},  32'd0);
        check({tag, "_rlast_a"},   {31'b0, rlast_a},   32'd0);
        check({tag, "_rresp_a"},   {30'b0, rresp_a},   32'd0);
        check({tag, "_rdata_a"},   rdata_a,            32'd0);
        check({tag, "_arready_b"}, {31'b0, arready_b}, 32'd0);
        check({tag, "_rvalid_b"},  {31'b0, rvalid_b},  32'd0);
    endtask

    // -----------------------------------------------------------------------
    // Test sequence
    // -----------------------------------------------------------------------
    initial begin
        bit ok;
        rst       = 1'b0;
        araddr    = '0;
        arlen     = '0;
        arsize    = '0;
        arburst   = '0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        coll_data = '0;
        hold_v    = '{1'b0, 1'b0};
        n_pop     = '{0, 0};

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("release_arready_comb", {31'b0, arready_a}, 32'd0);
        @(posedge clk);
        #1;
        check("release_arready_a", {31'b0, arready_a}, 32'd1);
        check("release_arready_b", {31'b0, arready_b}, 32'd1);

        for (int k = 0; k < 1024; k++) write_word(10'(k), 32'h100 + 32'(k));
        write_word(10'd3, 32'hDEAD_BEEF);

        rr_mode = 0; issue(12'h00C, 8'd0, 3'b010, 2'b01); wait_idle();   // single read
        rr_mode = 1; issue(12'h010, 8'd3, 3'b010, 2'b01); wait_idle();   // INCR + backpressure
        rr_mode = 2; issue(12'hFFC, 8'd1, 3'b010, 2'b01); wait_idle();   // wrap
        rr_mode = 0; issue(12'h008, 8'd2, 3'b010, 2'b00); wait_idle();   // FIXED
        issue(12'h000, 8'd0, 3'b001, 2'b01); wait_idle();                // bad size
        rr_mode = 1; issue(12'h400, 8'd1, 3'b010, 2'b01); wait_idle();   // out of range on b
        issue(12'h7F0, 8'd2, 3'b010, 2'b10); wait_idle();                // reserved burst
        issue(12'h100, 8'd0, 3'b010, 2'b11); wait_idle();
        rr_mode = 0; issue(12'h013, 8'd1, 3'b010, 2'b01); wait_idle();   // low bits ignored

        // Preload write to the word being fetched: the read sees the old word.
        coll_en   = 1'b1;
        coll_data = 32'hA5A5_0008;
        issue(12'h020, 8'd0, 3'b010, 2'b01); wait_idle();
        coll_en   = 1'b0;
        issue(12'h020, 8'd0, 3'b010, 2'b01); wait_idle();

        // Word 0x105 is beyond the small instance; it must not alias to word 5.
        write_word(10'h105, 32'hBAD0_0105);
        issue(12'h014, 8'd0, 3'b010, 2'b01); wait_idle();
        issue(12'h414, 8'd0, 3'b010, 2'b01); wait_idle();

        // Reset while beat 2 of an 8-beat burst is presented.
        rr_mode = 2;
        issue(12'h040, 8'd7, 3'b010, 2'b01);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); ok = (n_pop[0] >= 1); end
        for (int i = 0; i < 200 && rvalid_a; i++) @(negedge clk);
        for (int i = 0; i < 200 && !rvalid_a; i++) @(negedge clk);
        check("midburst_beat2_reached", {31'b0, ok & rvalid_a}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midburst");
        q0.delete();
        q1.delete();
        hold_v = '{1'b0, 1'b0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rerelease_arready_comb", {31'b0, arready_a}, 32'd0);
        @(posedge clk);
        #1;
        check("rerelease_arready_a", {31'b0, arready_a}, 32'd1);
        check("rerelease_arready_b", {31'b0, arready_b}, 32'd1);
        rr_mode = 0;
        issue(12'h040, 8'd3, 3'b010, 2'b01); wait_idle();

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
                write_word(10'($urandom), $urandom);
            end
            rr_mode = int'($urandom_range(0, 2));
            issue(12'($urandom),
                  8'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b010,
                  2'($urandom));
            wait_idle();
        end

        check("queue_a_drained", q0.size(), 32'd0);
        check("queue_b_drained", q1.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_read_slave.md
AXI_READ_SLAVE -- requirements
Module: axi_read_slave

Interface
REQ-001 Parameter MEM_WORDS, default 1024, sets the number of 32-bit memory words; only values of 1024 or less are legal.
REQ-002 clk  in  1  single clock; all logic is rising-edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 s_axi_araddr  in  12  byte address; word index = araddr[11:2].
REQ-005 s_axi_arlen  in  8  beats minus 1.
REQ-006 s_axi_arsize  in  3  transfer size; only 3'b010 is supported.
REQ-007 s_axi_arburst  in  2  burst type: 00 FIXED, 01 INCR, others unsupported.
REQ-008 s_axi_arvalid  in  1  address valid.
REQ-009 s_axi_arready  out  1  address ready.
REQ-010 s_axi_rdata  out  32  read data.
REQ-011 s_axi_rresp  out  2  read response: 00 OKAY, 10 SLVERR.
REQ-012 s_axi_rlast  out  1  final beat of the burst.
REQ-013 s_axi_rvalid  out  1  read data valid.
REQ-014 s_axi_rready  in  1  read data ready.
REQ-015 mem_we, mem_waddr[9:0], mem_wdata[31:0]  in  preload write port; a write occurs when mem_we=1.

Function
REQ-016 The FSM SHALL have four states: IDLE, FETCH, DATA and DONE.
REQ-017 IDLE transitions:
- arready=1, rvalid=0.
- On arvalid&&arready: capture addr, len, size and burst, load beat counter = arlen, go to FETCH.
REQ-018 arready SHALL be 0 in every state other than IDLE, so at most one burst is outstanding.
REQ-019 FETCH SHALL register mem[word_index] into rdata, set rvalid=1, and go to DATA.
- First rvalid appears exactly 2 cycles after the AR handshake edge.
REQ-020 DATA SHALL hold rdata, rresp, rlast and rvalid stable until rvalid&&rready; waiting on backpressure has no limit (no timeout).
REQ-021 rlast SHALL be 1 exactly when the beat counter is 0.
REQ-022 On a handshake in DATA:
- Not last: decrement counter, advance address, rvalid=0, go to FETCH.
- Last: rvalid=0, go to DONE.
- Each beat takes at least 2 cycles.
REQ-023 DONE SHALL last one cycle with arready=0, then go to IDLE.
REQ-024 Address advance per burst type:
- INCR: address += 4, modulo 4096, so 0xFFC wraps to 0x000.
- FIXED: address unchanged.
REQ-025 Out-of-range or unsupported requests SHALL return rresp=SLVERR (10) for that beat, with rdata=32'h0.
- Applies when the word index is >= MEM_WORDS, when arsize != 010, or when arburst is 10 or 11.
- Beat count and rlast are unaffected.
- Addressing for unsupported bursts follows INCR.
- All other beats return rresp=00.
REQ-026 Preload writes:
- Accepted in any state.
- If a write and the FETCH read hit the same word in the same cycle, the read returns the old data (read-first).
- Writes with mem_waddr >= MEM_WORDS are ignored.
REQ-027 araddr[1:0] SHALL be ignored, and the data path is always word-aligned.
REQ-028 Input changes on AR while busy SHALL have no effect on the burst in flight.

Reset
REQ-029 Asserting rst SHALL immediately force:
- state=IDLE.
- arready=0, rvalid=0, rlast=0, rresp=00, rdata=0.
- Beat counter and captured address cleared.
- This applies mid-burst as well; the rest of the burst is abandoned.
REQ-030 arready SHALL rise in the first clock cycle after rst deasserts, not combinationally on release.
REQ-031 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-032 Single read:
- Preload mem[3]=0xDEADBEEF.
- Request araddr=0x00C, arlen=0, INCR, rready=1.
- Expect rdata=0xDEADBEEF, rresp=00, rlast=1, with rvalid 2 cycles after the AR handshake.
REQ-033 INCR burst with backpressure:
- Preload mem[k]=k+0x100.
- Request araddr=0x010, arlen=3.
- Toggle rready 0/1.
- Expect data 0x104..0x107, rlast only on the 4th beat, and data stable while rready=0.
REQ-034 Wrap and FIXED:
- araddr=0xFFC, arlen=1, INCR returns mem[1023] then mem[0].
- FIXED, arlen=2 at 0x008 returns mem[2] three times.
REQ-035 Errors:
- arsize=3'b001 returns a single beat with rresp=10 and rdata=0.
- With MEM_WORDS=256, araddr=0x400 returns SLVERR.
- arready=0 throughout both bursts.
REQ-036 Reset mid-burst:
- Assert rst during beat 2 of an arlen=7 burst.
- Expect rvalid=0 immediately.
- After release, arready=1 on the next edge, and a fresh read returns the preloaded data, which is unchanged.
